// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: shadows rd/valid of every instruction past decode,
// stalls decode on not-yet-ready sources and registers the EX forward selects.
module pipe_hazard_ctrl #(
    parameter int STAGES  = 3,
    parameter int ALU_RDY = 2,
    parameter int LD_RDY  = 3,
    parameter int BR_SLOT = 1,
    parameter int CNT_W   = 16,
    parameter int FW      = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [4:0]        id_rd,
    input  logic              id_reg_wr,
    input  logic              id_is_load,
    output logic              id_stall,
    output logic [FW-1:0]     ex_fwd_a,
    output logic [FW-1:0]     ex_fwd_b,
    output logic [STAGES-1:0] slot_valid,
    output logic [CNT_W-1:0]  stall_cnt
);

    // The WB slot never produces a match (write-first register file), so only its valid bit is kept.
    logic [STAGES:1]        v_q;
    logic [STAGES-1:1]      wr_q;
    logic [STAGES-1:1]      ld_q;
    logic [STAGES-1:1][4:0] rd_q;

    logic [FW-1:0] fwd_a_nxt, fwd_b_nxt;
    logic          ld_a, ld_b;
    logic          haz_a, haz_b;
    logic          advance;

    always_comb begin
        fwd_a_nxt = '0;
        fwd_b_nxt = '0;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        // Descending scan so the youngest (smallest k) producer is written last and wins.
        for (int k = STAGES - 1; k >= 1; k--) begin
            if (v_q[k] && wr_q[k] && (rd_q[k] != 5'd0)) begin
                if (id_rs1_used && (id_rs1 != 5'd0) && (rd_q[k] == id_rs1)) begin
                    fwd_a_nxt = FW'(k + 1);
                    ld_a      = ld_q[k];
                end
                if (id_rs2_used && (id_rs2 != 5'd0) && (rd_q[k] == id_rs2)) begin
                    fwd_b_nxt = FW'(k + 1);
                    ld_b      = ld_q[k];
                end
            end
        end
        haz_a    = (fwd_a_nxt != '0) && (int'(fwd_a_nxt) < (ld_a ? LD_RDY : ALU_RDY));
        haz_b    = (fwd_b_nxt != '0) && (int'(fwd_b_nxt) < (ld_b ? LD_RDY : ALU_RDY));
        id_stall = id_valid && (haz_a || haz_b) && !flush;
        advance  = id_valid && !id_stall && !flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q       <= '0;
            wr_q      <= '0;
            ld_q      <= '0;
            rd_q      <= '0;
            ex_fwd_a  <= '0;
            ex_fwd_b  <= '0;
            stall_cnt <= '0;
        end else if (!hold) begin
            v_q[1]  <= advance;
            wr_q[1] <= id_reg_wr;
            ld_q[1] <= id_is_load;
            rd_q[1] <= id_rd;
            for (int j = 2; j <= STAGES; j++) begin
                v_q[j] <= v_q[j-1] && !(flush && (j <= BR_SLOT));
            end
            for (int j = 2; j <= STAGES - 1; j++) begin
                wr_q[j] <= wr_q[j-1];
                ld_q[j] <= ld_q[j-1];
                rd_q[j] <= rd_q[j-1];
            end
            ex_fwd_a <= advance ? fwd_a_nxt : '0;
            ex_fwd_b <= advance ? fwd_b_nxt : '0;
            if (id_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign slot_valid = v_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default 3-slot instance and a 5-slot, BR_SLOT=2,
// 2-bit-counter instance driven by the same decode stream.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       hold, flush, id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_reg_wr, id_is_load;

    logic        stall3, stall5;
    logic [1:0]  fwd_a3, fwd_b3;
    logic [2:0]  fwd_a5, fwd_b5;
    logic [2:0]  sv3;
    logic [4:0]  sv5;
    logic [15:0] cnt3;
    logic [1:0]  cnt5;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut3 (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_is_load(id_is_load),
        .id_stall(stall3), .ex_fwd_a(fwd_a3), .ex_fwd_b(fwd_b3), .slot_valid(sv3), .stall_cnt(cnt3)
    );

    pipe_hazard_ctrl #(.STAGES(5), .BR_SLOT(2), .CNT_W(2)) dut5 (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_is_load(id_is_load),
        .id_stall(stall5), .ex_fwd_a(fwd_a5), .ex_fwd_b(fwd_b5), .slot_valid(sv5), .stall_cnt(cnt5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2,
                          input logic [4:0] rd, input logic w, input logic l);
        id_valid    = v;
        id_rs1      = r1;
        id_rs1_used = u1;
        id_rs2      = r2;
        id_rs2_used = u2;
        id_rd       = rd;
        id_reg_wr   = w;
        id_is_load  = l;
        #1;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_reg_wr = 1'b0; id_is_load = 1'b0;
        #12 rst = 1'b0;
        #1;
        check("rst_slot_valid", 32'(sv3), 0);
        check("rst_fwd_a", 32'(fwd_a3), 0);
        check("rst_fwd_b", 32'(fwd_b3), 0);
        check("rst_cnt", 32'(cnt3), 0);
        check("rst_stall", 32'(stall3), 0);
        check("rst_slot_valid5", 32'(sv5), 0);

        // add x5 ; sub x6, x5
        set_id(1, 0, 0, 0, 0, 5, 1, 0);
        check("add_stall", 32'(stall3), 0);
        tick;
        check("add_slots", 32'(sv3), 3'b001);
        set_id(1, 5, 1, 0, 0, 6, 1, 0);
        check("alu_use_stall", 32'(stall3), 0);
        tick;
        check("alu_use_fwd_a", 32'(fwd_a3), 2);
        check("alu_use_fwd_b", 32'(fwd_b3), 0);
        check("alu_use_slots", 32'(sv3), 3'b011);

        // lw x7 ; add x8, x0, x7 -> one stall cycle, then forward from slot 3
        set_id(1, 0, 0, 0, 0, 7, 1, 1);
        tick;
        set_id(1, 0, 1, 7, 1, 8, 1, 0);
        check("ld_use_stall", 32'(stall3), 1);
        tick;
        check("ld_use_bubble", 32'(sv3), 3'b110);
        check("ld_use_cnt", 32'(cnt3), 1);
        check("ld_use_stall_gone", 32'(stall3), 0);
        tick;
        check("ld_use_fwd_b", 32'(fwd_b3), 3);
        check("ld_use_fwd_a_x0", 32'(fwd_a3), 0);
        check("ld_use_slots", 32'(sv3), 3'b101);

        // add x3 ; addi x3, x3 ; consumer of x3 -> youngest producer wins
        set_id(1, 0, 0, 0, 0, 3, 1, 0);
        tick;
        set_id(1, 3, 1, 0, 0, 3, 1, 0);
        tick;
        set_id(1, 3, 1, 3, 0, 9, 1, 0);
        check("youngest_stall", 32'(stall3), 0);
        tick;
        check("youngest_fwd_a", 32'(fwd_a3), 2);
        check("unused_fwd_b", 32'(fwd_b3), 0);

        // write to x0 is never a producer; x3 now only in the last slot of dut3
        set_id(1, 0, 0, 0, 0, 0, 1, 0);
        tick;
        set_id(1, 0, 1, 3, 1, 10, 1, 0);
        check("x0_stall", 32'(stall3), 0);
        tick;
        check("x0_fwd_a", 32'(fwd_a3), 0);
        check("wb_ignored_fwd_b", 32'(fwd_b3), 0);
        check("deep_fwd_b5", 32'(fwd_b5), 4);

        // lw x11 ; consumer rs1=x11 under 3 cycles of hold
        set_id(1, 0, 0, 0, 0, 11, 1, 1);
        tick;
        hold = 1'b1;
        set_id(1, 11, 1, 0, 0, 12, 1, 0);
        check("hold_stall", 32'(stall3), 1);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("hold_slots", 32'(sv3), 3'b111);
            check("hold_cnt", 32'(cnt3), 1);
        end
        hold = 1'b0;
        #1;
        check("post_hold_stall", 32'(stall3), 1);
        tick;
        check("post_hold_cnt", 32'(cnt3), 2);
        check("post_hold_slots", 32'(sv3), 3'b110);
        check("post_hold_stall_gone", 32'(stall3), 0);
        tick;
        check("post_hold_fwd_a", 32'(fwd_a3), 3);

        // add x1 ; lw x7, x1 ; load-use with flush in the same cycle
        set_id(1, 0, 0, 0, 0, 1, 1, 0);
        tick;
        set_id(1, 1, 1, 0, 0, 7, 1, 1);
        tick;
        check("pre_flush_fwd_a", 32'(fwd_a3), 2);
        flush = 1'b1;
        set_id(1, 0, 0, 7, 1, 8, 1, 0);
        check("flush_stall", 32'(stall3), 0);
        check("flush_stall5", 32'(stall5), 0);
        tick;
        flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        check("flush_slots", 32'(sv3), 3'b110);
        check("flush_slots5", 32'(sv5[2:0]), 3'b100);
        check("flush_fwd_a", 32'(fwd_a3), 0);
        check("flush_fwd_b", 32'(fwd_b3), 0);
        check("flush_cnt", 32'(cnt3), 2);

        // three more load-use stalls: 16-bit counter reaches 5, 2-bit counter saturates at 3
        for (int i = 0; i < 3; i++) begin
            set_id(1, 0, 0, 0, 0, 13, 1, 1);
            tick;
            set_id(1, 0, 0, 13, 1, 14, 1, 0);
            check("loop_stall", 32'(stall3), 1);
            tick;
            tick;
        end
        check("cnt_total", 32'(cnt3), 5);
        check("cnt_saturated", 32'(cnt5), 3);

        // async reset in the middle of a load-use stall
        set_id(1, 0, 0, 0, 0, 15, 1, 1);
        tick;
        set_id(1, 15, 1, 0, 0, 16, 1, 0);
        check("pre_rst_stall", 32'(stall3), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_stall", 32'(stall3), 0);
        check("mid_rst_slots", 32'(sv3), 0);
        check("mid_rst_cnt", 32'(cnt3), 0);
        check("mid_rst_cnt5", 32'(cnt5), 0);
        rst = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        check("after_rst_slots", 32'(sv3), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
